// File: rtl/layer3_train_scheduler_if.sv
// Shared element type and the sample/layer/result bus of the layer-3 training
// scheduler.
//   zero2one_t : unsigned Q0.8 value in [0,1)
//   slave  modport : scheduler side (takes samples, drives the layer, returns results)
//   master modport : environment side (sample source, 3-neuron layer, result sink)
package layer3_train_pkg;
  localparam int unsigned Z2O_W = 8;
  typedef logic [Z2O_W-1:0] zero2one_t;
endpackage

interface layer3_train_if #(
  parameter int unsigned N = 16
);
  import layer3_train_pkg::*;

  logic                  s_valid;
  logic                  s_ready;
  zero2one_t [N-1:0]     s_in;
  zero2one_t [2:0]       s_expected;
  logic                  lyr_valid;
  logic                  lyr_learn;
  zero2one_t [N-1:0]     lyr_in;
  zero2one_t [2:0]       lyr_expected;
  zero2one_t [2:0]       lyr_out;
  logic                  res_valid;
  zero2one_t [2:0]       res_out;

  modport slave (
    input  s_valid, s_in, s_expected, lyr_out,
    output s_ready, lyr_valid, lyr_learn, lyr_in, lyr_expected, res_valid, res_out
  );

  modport master (
    output s_valid, s_in, s_expected, lyr_out,
    input  s_ready, lyr_valid, lyr_learn, lyr_in, lyr_expected, res_valid, res_out
  );
endinterface

// File: rtl/layer3_train_scheduler.sv
// Epoch/sample sequencer for a 3-neuron learning layer: fetches a sample,
// strobes a forward pass, waits SETTLE_CYCLES, captures the layer outputs and
// optionally strobes a learn step, for epochs x samples_per_epoch samples.
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   start, mode_learn     : run request (IDLE only), train/infer select
//   epochs, samples_per_epoch : run dimensions, latched at start
//   sif (slave)           : sample handshake, layer strobes/data, captured results
//   busy, done            : run in progress, one-cycle completion pulse
//   epoch_idx, sample_idx : current position in the run
// Optional feature: define LAYER3_TRAIN_ERR_ACC_EN to add err_epoch[31:0], the
// saturating per-epoch sum of |lyr_out - lyr_expected| over all captures.
module layer3_train_scheduler
  import layer3_train_pkg::*;
#(
  parameter int unsigned N             = 16,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        mode_learn,
  input  logic [15:0] epochs,
  input  logic [15:0] samples_per_epoch,
  layer3_train_if.slave sif,
  output logic        busy,
  output logic        done,
  output logic [15:0] epoch_idx,
  output logic [15:0] sample_idx
`ifdef LAYER3_TRAIN_ERR_ACC_EN
  ,
  output logic [31:0] err_epoch
`endif
);

  localparam int unsigned IDX_W = 16;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned IN_W  = N * Z2O_W;
  localparam int unsigned EXP_W = 3 * Z2O_W;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_FWD, ST_SETTLE, ST_LEARN, ST_NEXT, ST_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   settle_cnt, settle_cnt_nxt;
  logic [IDX_W-1:0]   epochs_q, spe_q;
  logic               mode_q;
  logic               accept_c, capture_c, last_sample_c, last_epoch_c;
  logic               s_ready_nxt, lyr_valid_nxt, lyr_learn_nxt, busy_nxt, done_nxt;

  assign accept_c      = (state == ST_FETCH) && sif.s_valid && sif.s_ready;
  assign last_sample_c = (sample_idx == spe_q - IDX_W'(1));
  assign last_epoch_c  = (epoch_idx == epochs_q - IDX_W'(1));

  // Settle counter numbers the SETTLE cycles from 0.
  assign settle_cnt_nxt = (state == ST_SETTLE) ? settle_cnt + CNT_W'(1) : '0;
  // Capture on the edge that enters the last SETTLE cycle so res_valid shows in it.
  assign capture_c = (state_nxt == ST_SETTLE) &&
                     (settle_cnt_nxt == CNT_W'(SETTLE_CYCLES - 1));

  // State register plus registered control outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      sif.s_ready   <= 1'b0;
      sif.lyr_valid <= 1'b0;
      sif.lyr_learn <= 1'b0;
      sif.res_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      sif.s_ready   <= s_ready_nxt;
      sif.lyr_valid <= lyr_valid_nxt;
      sif.lyr_learn <= lyr_learn_nxt;
      sif.res_valid <= capture_c;
      busy          <= busy_nxt;
      done          <= done_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = (epochs == '0 || samples_per_epoch == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH:  if (accept_c) state_nxt = ST_FWD;
      ST_FWD:    state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) state_nxt = mode_q ? ST_LEARN : ST_NEXT;
      ST_LEARN:  state_nxt = ST_NEXT;
      ST_NEXT:   state_nxt = (last_sample_c && last_epoch_c) ? ST_DONE : ST_FETCH;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered strobes line up with it.
  always_comb begin
    s_ready_nxt   = 1'b0;
    lyr_valid_nxt = 1'b0;
    lyr_learn_nxt = 1'b0;
    done_nxt      = 1'b0;
    busy_nxt      = (state_nxt != ST_IDLE);
    case (state_nxt)
      ST_FETCH: s_ready_nxt   = 1'b1;
      ST_FWD:   lyr_valid_nxt = 1'b1;
      ST_LEARN: lyr_learn_nxt = 1'b1;
      ST_DONE:  done_nxt      = 1'b1;
      default:  ;
    endcase
  end

`ifdef LAYER3_TRAIN_ERR_ACC_EN
  logic [31:0] err_acc;
  logic [9:0]  err_sum_c;
  logic [32:0] err_add_c;

  // Sum of absolute per-neuron errors for the sample being captured.
  always_comb begin
    err_sum_c = '0;
    for (int k = 0; k < 3; k++) begin
      if (sif.lyr_out[k] > sif.lyr_expected[k])
        err_sum_c = err_sum_c + 10'(sif.lyr_out[k] - sif.lyr_expected[k]);
      else
        err_sum_c = err_sum_c + 10'(sif.lyr_expected[k] - sif.lyr_out[k]);
    end
  end

  assign err_add_c = 33'(err_acc) + 33'(err_sum_c);

  // Accumulator clears at every epoch start; err_epoch loads when an epoch ends.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_acc   <= '0;
      err_epoch <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        err_acc <= '0;
      end else if (capture_c) begin
        err_acc <= err_add_c[32] ? '1 : err_add_c[31:0];
      end else if (state == ST_NEXT && last_sample_c) begin
        err_acc   <= '0;
        err_epoch <= err_acc;
      end
    end
  end
`endif

  // Run parameters, indices, settle counter and layer/result data registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      epochs_q         <= '0;
      spe_q            <= '0;
      mode_q           <= 1'b0;
      epoch_idx        <= '0;
      sample_idx       <= '0;
      settle_cnt       <= '0;
      sif.lyr_in       <= '0;
      sif.lyr_expected <= '0;
      sif.res_out      <= '0;
    end else begin
      settle_cnt <= settle_cnt_nxt;
      if (state == ST_IDLE && start) begin
        epochs_q   <= epochs;
        spe_q      <= samples_per_epoch;
        mode_q     <= mode_learn;
        epoch_idx  <= '0;
        sample_idx <= '0;
      end
      if (accept_c) begin
        sif.lyr_in       <= IN_W'(sif.s_in);
        sif.lyr_expected <= EXP_W'(sif.s_expected);
      end
      if (capture_c) sif.res_out <= sif.lyr_out;
      if (state == ST_NEXT) begin
        if (last_sample_c) begin
          sample_idx <= '0;
          epoch_idx  <= epoch_idx + IDX_W'(1);
        end else begin
          sample_idx <= sample_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_layer3_train_scheduler.sv
// Directed bench for layer3_train_scheduler (N=16, SETTLE_CYCLES=2).
module tb_layer3_train_scheduler;
  import layer3_train_pkg::*;

  localparam int unsigned N = 16;
  localparam int unsigned SETTLE = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode_learn = 1'b0;
  logic [15:0] epochs = '0;
  logic [15:0] samples_per_epoch = '0;
  logic        busy, done;
  logic [15:0] epoch_idx, sample_idx;
`ifdef LAYER3_TRAIN_ERR_ACC_EN
  logic [31:0] err_epoch;
`endif

  layer3_train_if #(.N(N)) bus ();

  layer3_train_scheduler #(.N(N), .SETTLE_CYCLES(SETTLE)) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .mode_learn        (mode_learn),
    .epochs            (epochs),
    .samples_per_epoch (samples_per_epoch),
    .sif               (bus),
    .busy              (busy),
    .done              (done),
    .epoch_idx         (epoch_idx),
    .sample_idx        (sample_idx)
`ifdef LAYER3_TRAIN_ERR_ACC_EN
    ,
    .err_epoch         (err_epoch)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  zero2one_t [N-1:0] pat_a, pat_b, pat_c;
  zero2one_t [2:0]   exp_a, exp_b, out_a, out_b;

  // Event monitor, sampled mid-cycle.
  int cyc = 0;
  int acc_cnt, lv_cnt, ll_cnt, rv_cnt, done_cnt, both_cnt, strobe_cnt, wraps;
  int first_acc_cyc, last_acc_cyc, first_rv_cyc, done_cyc, start_cyc;
  logic [15:0] sidx_prev;
  logic [7:0]  eidx_seen;
  zero2one_t [2:0] last_res;

  task automatic clear_mon();
    acc_cnt = 0; lv_cnt = 0; ll_cnt = 0; rv_cnt = 0; done_cnt = 0; both_cnt = 0;
    strobe_cnt = 0; wraps = 0; first_acc_cyc = -1; last_acc_cyc = -1;
    first_rv_cyc = -1; done_cyc = -1; start_cyc = -1; sidx_prev = '0;
    eidx_seen = '0; last_res = '0;
  endtask

  always @(negedge clock) begin
    cyc++;
    if (start) start_cyc = cyc;
    if (bus.s_ready && bus.s_valid) begin
      if (acc_cnt == 0) first_acc_cyc = cyc;
      acc_cnt++;
      last_acc_cyc = cyc;
    end
    if (bus.lyr_valid) lv_cnt++;
    if (bus.lyr_learn) ll_cnt++;
    if (bus.lyr_valid && bus.lyr_learn) both_cnt++;
    if (bus.lyr_valid || bus.lyr_learn || bus.s_ready) strobe_cnt++;
    if (bus.res_valid) begin
      if (rv_cnt == 0) first_rv_cyc = cyc;
      rv_cnt++;
      last_res = bus.res_out;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (sidx_prev == 16'd1 && sample_idx == 16'd0) wraps++;
    sidx_prev = sample_idx;
    if (epoch_idx < 16'd8) eidx_seen[epoch_idx[2:0]] = 1'b1;
  end

  // Called at posedge+1; start is high for exactly one cycle.
  task automatic pulse_start(input logic [15:0] ep, input logic [15:0] spe, input logic ml);
    epochs = ep; samples_per_epoch = spe; mode_learn = ml; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0h exp=0", done); end
    checks++; if ({bus.s_ready, bus.lyr_valid, bus.lyr_learn, bus.res_valid} !== 4'b0) begin failures++; $display("FAIL reset_strobes got=%0h exp=0", {bus.s_ready, bus.lyr_valid, bus.lyr_learn, bus.res_valid}); end
    checks++; if (bus.res_out !== '0) begin failures++; $display("FAIL reset_res_out got=%0h exp=0", bus.res_out); end
    checks++; if (bus.lyr_in !== '0) begin failures++; $display("FAIL reset_lyr_in got=%0h exp=0", bus.lyr_in); end
    checks++; if (bus.lyr_expected !== '0) begin failures++; $display("FAIL reset_lyr_expected got=%0h exp=0", bus.lyr_expected); end
    checks++; if ({epoch_idx, sample_idx} !== 32'h0) begin failures++; $display("FAIL reset_indices got=%0h exp=0", {epoch_idx, sample_idx}); end
`ifdef LAYER3_TRAIN_ERR_ACC_EN
    checks++; if (err_epoch !== 32'h0) begin failures++; $display("FAIL reset_err_epoch got=%0h exp=0", err_epoch); end
`endif
    reset = 1'b0;
  endtask

  // 1 epoch x 3 samples, train mode, source always valid.
  task automatic test_learn_run();
    bus.s_in = pat_a; bus.s_expected = exp_a; bus.lyr_out = out_a; bus.s_valid = 1'b1;
    clear_mon();
    pulse_start(16'd1, 16'd3, 1'b1);
    wait_done(200);
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL learn_done_count got=%0d exp=1", done_cnt); end
    checks++; if (lv_cnt !== 3) begin failures++; $display("FAIL learn_lyr_valid got=%0d exp=3", lv_cnt); end
    checks++; if (ll_cnt !== 3) begin failures++; $display("FAIL learn_lyr_learn got=%0d exp=3", ll_cnt); end
    checks++; if (rv_cnt !== 3) begin failures++; $display("FAIL learn_res_valid got=%0d exp=3", rv_cnt); end
    checks++; if (both_cnt !== 0) begin failures++; $display("FAIL learn_valid_and_learn got=%0d exp=0", both_cnt); end
    // accept cycle -> FWD -> SETTLE x2 (res_valid in the last one)
    checks++; if (first_rv_cyc - first_acc_cyc !== 3) begin failures++; $display("FAIL learn_latency got=%0d exp=3", first_rv_cyc - first_acc_cyc); end
    // accept -> FWD, SETTLE, SETTLE, LEARN, NEXT, DONE
    checks++; if (done_cyc - last_acc_cyc !== 6) begin failures++; $display("FAIL learn_done_delay got=%0d exp=6", done_cyc - last_acc_cyc); end
    checks++; if (last_res !== out_a) begin failures++; $display("FAIL learn_res_out got=%0h exp=%0h", last_res, out_a); end
    checks++; if (bus.lyr_in !== pat_a) begin failures++; $display("FAIL learn_lyr_in got=%0h exp=%0h", bus.lyr_in, pat_a); end
    checks++; if (bus.lyr_expected !== exp_a) begin failures++; $display("FAIL learn_lyr_expected got=%0h exp=%0h", bus.lyr_expected, exp_a); end
    checks++; if ({epoch_idx, sample_idx} !== {16'd1, 16'd0}) begin failures++; $display("FAIL learn_final_idx got=%0h exp=10000", {epoch_idx, sample_idx}); end
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL learn_idle_after got=%0h exp=0", {busy, done}); end
  endtask

  // 2 epochs x 2 samples, inference only.
  task automatic test_infer_run();
    bus.s_in = pat_b; bus.s_expected = exp_b; bus.lyr_out = out_b; bus.s_valid = 1'b1;
    clear_mon();
    pulse_start(16'd2, 16'd2, 1'b0);
    wait_done(200);
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL infer_done_count got=%0d exp=1", done_cnt); end
    checks++; if (rv_cnt !== 4) begin failures++; $display("FAIL infer_res_valid got=%0d exp=4", rv_cnt); end
    checks++; if (lv_cnt !== 4) begin failures++; $display("FAIL infer_lyr_valid got=%0d exp=4", lv_cnt); end
    checks++; if (ll_cnt !== 0) begin failures++; $display("FAIL infer_lyr_learn got=%0d exp=0", ll_cnt); end
    checks++; if (eidx_seen !== 8'h07) begin failures++; $display("FAIL infer_epoch_steps got=%0h exp=7", eidx_seen); end
    checks++; if (wraps !== 2) begin failures++; $display("FAIL infer_sample_wraps got=%0d exp=2", wraps); end
    checks++; if ({epoch_idx, sample_idx} !== {16'd2, 16'd0}) begin failures++; $display("FAIL infer_final_idx got=%0h exp=20000", {epoch_idx, sample_idx}); end
    // accept -> FWD, SETTLE, SETTLE, NEXT, DONE
    checks++; if (done_cyc - last_acc_cyc !== 5) begin failures++; $display("FAIL infer_done_delay got=%0d exp=5", done_cyc - last_acc_cyc); end
    checks++; if (last_res !== out_b) begin failures++; $display("FAIL infer_res_out got=%0h exp=%0h", last_res, out_b); end
  endtask

  // Zero epoch or sample count finishes immediately with no layer activity.
  task automatic test_zero_counts();
    bus.s_valid = 1'b1;
    clear_mon();
    pulse_start(16'd0, 16'd5, 1'b1);
    wait_done(20);
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL zero_ep_done got=%0d exp=1", done_cnt); end
    checks++; if (done_cyc - start_cyc !== 1) begin failures++; $display("FAIL zero_ep_done_delay got=%0d exp=1", done_cyc - start_cyc); end
    checks++; if (strobe_cnt !== 0) begin failures++; $display("FAIL zero_ep_strobes got=%0d exp=0", strobe_cnt); end
    clear_mon();
    pulse_start(16'd3, 16'd0, 1'b0);
    wait_done(20);
    checks++; if (done_cnt !== 1 || strobe_cnt !== 0) begin failures++; $display("FAIL zero_spe got=%0d/%0d exp=1/0", done_cnt, strobe_cnt); end
    checks++; if ({epoch_idx, sample_idx} !== 32'h0) begin failures++; $display("FAIL zero_spe_idx got=%0h exp=0", {epoch_idx, sample_idx}); end
  endtask

  // Source withholds samples in FETCH; a second start meanwhile is ignored.
  task automatic test_stall();
    bus.s_valid = 1'b0; bus.s_in = pat_b; bus.lyr_out = out_a;
    clear_mon();
    pulse_start(16'd1, 16'd1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL stall_s_ready cyc=%0d got=%0h exp=1", i, bus.s_ready); end
      checks++; if (bus.lyr_in !== pat_b) begin failures++; $display("FAIL stall_lyr_in cyc=%0d got=%0h exp=%0h", i, bus.lyr_in, pat_b); end
      if (i == 2) bus.s_in = pat_c;
      start = (i == 4);
      if (i == 4) epochs = 16'd5;
      @(posedge clock); #1;
    end
    start = 1'b0;
    bus.s_valid = 1'b1;
    wait_done(100);
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL stall_done got=%0d exp=1", done_cnt); end
    checks++; if (lv_cnt !== 1) begin failures++; $display("FAIL stall_start_ignored got=%0d exp=1", lv_cnt); end
    checks++; if (bus.lyr_in !== pat_c) begin failures++; $display("FAIL stall_lyr_in_final got=%0h exp=%0h", bus.lyr_in, pat_c); end
  endtask

  // Reset in SETTLE (with start high), then a clean run.
  task automatic test_reset_mid();
    int i;
    bus.s_valid = 1'b1; bus.s_in = pat_a; bus.lyr_out = out_b;
    clear_mon();
    pulse_start(16'd1, 16'd2, 1'b1);
    for (i = 0; i < 50 && !bus.lyr_valid; i++) begin @(posedge clock); #1; end
    checks++; if (bus.lyr_valid !== 1'b1) begin failures++; $display("FAIL mid_reach_fwd got=%0h exp=1", bus.lyr_valid); end
    @(posedge clock); #1;
    reset = 1'b1; start = 1'b1; epochs = 16'd1; samples_per_epoch = 16'd1;
    @(posedge clock); #1;
    checks++; if ({bus.s_ready, bus.lyr_valid, bus.lyr_learn, bus.res_valid, busy, done} !== 6'b0) begin failures++; $display("FAIL mid_reset_ctrl got=%0h exp=0", {bus.s_ready, bus.lyr_valid, bus.lyr_learn, bus.res_valid, busy, done}); end
    checks++; if ({bus.res_out, bus.lyr_expected} !== '0) begin failures++; $display("FAIL mid_reset_res got=%0h exp=0", {bus.res_out, bus.lyr_expected}); end
    checks++; if (bus.lyr_in !== '0) begin failures++; $display("FAIL mid_reset_lyr_in got=%0h exp=0", bus.lyr_in); end
    checks++; if ({epoch_idx, sample_idx} !== 32'h0) begin failures++; $display("FAIL mid_reset_idx got=%0h exp=0", {epoch_idx, sample_idx}); end
    reset = 1'b0; start = 1'b0;
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_priority got=%0h exp=0", busy); end
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", done_cnt); end
    clear_mon();
    pulse_start(16'd1, 16'd1, 1'b0);
    wait_done(100);
    checks++; if (done_cnt !== 1 || rv_cnt !== 1) begin failures++; $display("FAIL mid_rerun got=%0d/%0d exp=1/1", done_cnt, rv_cnt); end
    checks++; if (last_res !== out_b) begin failures++; $display("FAIL mid_rerun_res got=%0h exp=%0h", last_res, out_b); end
  endtask

`ifdef LAYER3_TRAIN_ERR_ACC_EN
  // Each epoch: one sample with |err| = 1 + 0 + 2; accumulator clears per epoch.
  task automatic test_err_acc();
    zero2one_t [2:0] lo, ex;
    lo = {8'h50, 8'h40, 8'h30};
    ex = {8'h4E, 8'h40, 8'h31};
    bus.s_valid = 1'b1; bus.lyr_out = lo; bus.s_expected = ex;
    clear_mon();
    pulse_start(16'd2, 16'd1, 1'b1);
    wait_done(200);
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL err_done got=%0d exp=1", done_cnt); end
    checks++; if (err_epoch !== 32'd3) begin failures++; $display("FAIL err_epoch got=%0d exp=3", err_epoch); end
  endtask
`endif

  initial begin
    for (int i = 0; i < N; i++) begin
      pat_a[i] = 8'(i * 3 + 1);
      pat_b[i] = 8'(8'hF0 - i * 5);
    end
    pat_c = ~pat_b;
    exp_a = {8'h11, 8'h22, 8'h33};
    exp_b = {8'hA0, 8'hB0, 8'hC0};
    out_a = {8'h5A, 8'h6B, 8'h7C};
    out_b = {8'h01, 8'h80, 8'hFF};
    bus.s_valid = 1'b0; bus.s_in = '0; bus.s_expected = '0; bus.lyr_out = '0;
    clear_mon();

    test_reset();
    test_learn_run();
    test_infer_run();
    test_zero_counts();
    test_stall();
    test_reset_mid();
`ifdef LAYER3_TRAIN_ERR_ACC_EN
    test_err_acc();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
